// File: rtl/cpu_serial_tx_pkg.sv
// Shared types and frame constants for the CPU result serial transmitter.
package cpu_serial_tx_pkg;

  localparam int TX_DATA_W     = 8;
  localparam int TX_FLAG_W     = 4;
  localparam int TX_FRAME_BITS = TX_DATA_W + TX_FLAG_W;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_SYNC   = 2'd1,
    TX_SHIFT  = 2'd2,
    TX_PARITY = 2'd3
  } tx_state_e;

endpackage

// File: rtl/cpu_serial_tx_bitclk.sv
// Bit-hold counter: counts 0..BIT_CYCLES-1 while enabled and strobes o_bit_adv
// on the final count; cleared whenever disabled.
module cpu_tx_bitclk #(
  parameter int BIT_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_bit_adv
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_end;

  assign w_at_end  = (r_cnt == CW'(BIT_CYCLES - 1));
  assign o_bit_adv = i_en && w_at_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_serial_tx.sv
// Serial transmitter for ALU result + flags: sync strobe, then 12 bits MSB-first.
// Optional even-parity trailer bit when CPU_TX_PARITY_EN is defined.
module cpu_serial_tx
  import cpu_serial_tx_pkg::*;
#(
  parameter int DATA_W     = TX_DATA_W,
  parameter int FLAG_W     = TX_FLAG_W,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              tx_sync,
  output logic              tx_data,
  output logic              busy,
  output logic              done
);

  localparam int FB    = DATA_W + FLAG_W;
  localparam int CNT_W = $clog2(FB + 1);

  tx_state_e        r_state, w_state_nxt;
  logic [FB-1:0]    r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic             r_tx_sync, r_tx_data, r_busy, r_done;
  logic             w_tx_data_nxt;
  logic             w_hs, w_bit_en, w_bit_adv, w_last_bit;
`ifdef CPU_TX_PARITY_EN
  logic             r_parity;
`endif

  // Ready is held low during reset even though the state already reads IDLE.
  assign ld_ready   = (r_state == TX_IDLE) && rst_n;
  assign w_hs       = ld_valid && (r_state == TX_IDLE);
  assign w_bit_en   = (r_state == TX_SHIFT) || (r_state == TX_PARITY);
  assign w_last_bit = (r_bitcnt == CNT_W'(FB - 1));

  cpu_tx_bitclk #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bitclk (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (w_bit_en),
    .o_bit_adv (w_bit_adv)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    case (r_state)
      TX_IDLE: begin
        if (w_hs) begin
          w_state_nxt  = TX_SYNC;
          w_shreg_nxt  = {data_in, flags_in};
          w_bitcnt_nxt = '0;
        end
      end
      TX_SYNC: w_state_nxt = TX_SHIFT;
      TX_SHIFT: begin
        if (w_bit_adv) begin
          w_shreg_nxt  = r_shreg << 1;
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          if (w_last_bit) begin
`ifdef CPU_TX_PARITY_EN
            w_state_nxt = TX_PARITY;
`else
            w_state_nxt = TX_IDLE;
`endif
          end
        end
      end
      TX_PARITY: if (w_bit_adv) w_state_nxt = TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_tx_data_nxt = 1'b0;
    if (w_state_nxt == TX_SHIFT) begin
      w_tx_data_nxt = w_shreg_nxt[FB-1];
    end
`ifdef CPU_TX_PARITY_EN
    else if (w_state_nxt == TX_PARITY) begin
      w_tx_data_nxt = r_parity;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_tx_sync <= 1'b0;
      r_tx_data <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_tx_sync <= (w_state_nxt == TX_SYNC);
      r_tx_data <= w_tx_data_nxt;
      r_busy    <= (w_state_nxt != TX_IDLE);
      r_done    <= w_bit_en && (w_state_nxt == TX_IDLE);
    end
  end

`ifdef CPU_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_hs) begin
      r_parity <= ^{data_in, flags_in};
    end
  end
`endif

  assign tx_sync = r_tx_sync;
  assign tx_data = r_tx_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_cpu_serial_tx.sv
// Bench for cpu_serial_tx: BIT_CYCLES=1 and BIT_CYCLES=3 instances against a frame-level model.
module tb_cpu_serial_tx;

`ifdef CPU_TX_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] ld_valid, ld_ready, tx_sync, tx_data, busy, done;
  logic [7:0] data_in  [2];
  logic [3:0] flags_in [2];

  int n_checks = 0;
  int n_err    = 0;

  cpu_serial_tx #(.DATA_W(8), .FLAG_W(4), .BIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
    .data_in(data_in[0]), .flags_in(flags_in[0]), .tx_sync(tx_sync[0]),
    .tx_data(tx_data[0]), .busy(busy[0]), .done(done[0])
  );

  cpu_serial_tx #(.DATA_W(8), .FLAG_W(4), .BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
    .data_in(data_in[1]), .flags_in(flags_in[1]), .tx_sync(tx_sync[1]),
    .tx_data(tx_data[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // {ld_ready, tx_sync, tx_data, busy, done}
  function automatic logic [4:0] obs(int s);
    return {ld_ready[s], tx_sync[s], tx_data[s], busy[s], done[s]};
  endfunction

  task automatic check(input string nm, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b (rdy,sync,data,busy,done)", nm, got, exp);
    end
  endtask

  // Handshake happens at the next rising edge; checks every cycle up to and including done.
  task automatic check_frame(input int s, input logic [11:0] bits, input logic par,
                             input bit hold, output logic [7:0] nd, output logic [3:0] nf);
    int bc;
    int last;
    int idx;
    logic b;
    logic [4:0] e;
    bc   = (s == 1) ? 3 : 1;
    last = NB * bc + 2;
    nd   = '0;
    nf   = '0;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      ld_valid[s] = hold;
      nd = 8'($urandom);
      nf = 4'($urandom);
      data_in[s]  = nd;
      flags_in[s] = nf;
      @(negedge clk);
      if (k == 1) begin
        e = 5'b01010;
      end else if (k == last) begin
        e = 5'b10001;
      end else begin
        idx = (k - 2) / bc;
        b = (idx < 12) ? bits[11-idx] : par;
        e = {2'b00, b, 2'b10};
      end
      check($sformatf("dut%0d_cyc%0d", s, k), obs(s), e);
    end
  endtask

  task automatic run_frame(input int s, input logic [7:0] d, input logic [3:0] f,
                           input logic [11:0] bits, input logic par);
    logic [7:0] nd;
    logic [3:0] nf;
    @(posedge clk);
    #1;
    ld_valid[s] = 1'b1;
    data_in[s]  = d;
    flags_in[s] = f;
    @(negedge clk);
    check($sformatf("dut%0d_pre_hs", s), obs(s), 5'b10000);
    check_frame(s, bits, par, 1'b0, nd, nf);
    @(negedge clk);
    check($sformatf("dut%0d_post_idle", s), obs(s), 5'b10000);
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  d;
    logic [3:0]  f;
    logic [11:0] bits;
    logic        par;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] d0, nd, nd2;
    logic [3:0] f0, nf, nf2;
    logic [7:0] rd;
    logic [3:0] rf;
    int rs;

    rst_n    = 1'b0;
    ld_valid = '0;
    for (int i = 0; i < 2; i++) begin
      data_in[i]  = '0;
      flags_in[i] = '0;
    end

    tbl[0] = '{0, 8'hA5, 4'b1001, 12'b1010_0101_1001, 1'b0};
    tbl[1] = '{1, 8'h80, 4'h0,    12'b1000_0000_0000, 1'b1};
    tbl[2] = '{0, 8'h01, 4'h0,    12'b0000_0001_0000, 1'b1};
    tbl[3] = '{0, 8'h3C, 4'h2,    12'b0011_1100_0010, 1'b1};
    tbl[4] = '{1, 8'hFF, 4'hF,    12'b1111_1111_1111, 1'b0};
    tbl[5] = '{1, 8'hA5, 4'b1001, 12'b1010_0101_1001, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dut0", obs(0), 5'b00000);
    check("rst_dut1", obs(1), 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_dut0", obs(0), 5'b10000);
    check("rel_dut1", obs(1), 5'b10000);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].sel, tbl[i].d, tbl[i].f, tbl[i].bits, tbl[i].par);
    end

    // Back-to-back with ld_valid held and inputs churning every cycle.
    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1;
      d0 = 8'($urandom);
      f0 = 4'($urandom);
      ld_valid[s] = 1'b1;
      data_in[s]  = d0;
      flags_in[s] = f0;
      check_frame(s, {d0, f0}, ^{d0, f0}, 1'b1, nd, nf);
      check_frame(s, {nd, nf}, ^{nd, nf}, 1'b0, nd2, nf2);
      @(negedge clk);
      check($sformatf("b2b_idle_dut%0d", s), obs(s), 5'b10000);
    end

    // Reset during the fifth bit aborts the frame without a done pulse.
    @(posedge clk);
    #1;
    ld_valid[0] = 1'b1;
    data_in[0]  = 8'hFF;
    flags_in[0] = 4'hF;
    @(posedge clk);
    #1;
    ld_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_dut0", obs(0), 5'b00000);
    check("midrst_dut1", obs(1), 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("after_rst_cyc%0d", k), obs(0), 5'b10000);
    end
    run_frame(0, 8'h3C, 4'h2, 12'b0011_1100_0010, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rs = int'($urandom_range(0, 1));
      rd = 8'($urandom);
      rf = 4'($urandom);
      run_frame(rs, rd, rf, {rd, rf}, ^{rd, rf});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
